padd_sched: RTL and testbench
=============================

// Module: padd_sched
// PURPOSE
//  Shares one padder16 16-bit prefix adder between NREQ requesters. Each request carries an
//  opcode (ADD/SUB/ABS/NEG) and operands. Requests are arbitrated round-robin, mapped onto
//  the adder's (A,B,Cin) inputs, and returned through a registered result port tagged with
//  the requester id. Sits between the ALU issue logic and the shared adder datapath.
// PARAMETERS
//  NREQ   4                  number of requesters (2..8)
//  ID_W   $clog2(NREQ)       requester-id width (derived localparam, not overridable)
//  WIDTH  16                 datapath width (localparam, fixed by padder16)
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            synchronous reset, active-high
//  req_valid  in   NREQ         per-requester request valid
//  req_ready  out  NREQ         per-requester accept (one-hot or zero)
//  req_op     in   NREQ*2       per-requester opcode, slice i = [2i+1:2i]
//  req_a      in   NREQ*16      per-requester operand A
//  req_b      in   NREQ*16      per-requester operand B (ignored for ABS/NEG)
//  res_valid  out  1            result valid
//  res_ready  in   1            consumer accepts result
//  res_data   out  16           result
//  res_id     out  ID_W         requester index that issued this result
//  res_ovf    out  1            signed overflow flag (only with PADD_OVF_EN)
// BEHAVIOUR
//  - Reset: res_valid=0, res_data=0, res_id=0, res_ovf=0, rr pointer=0. req_ready=0 while rst.
//  - Opcode map into adder (A,B,Cin):
//      ADD=0: (a, b, 0); SUB=1: (a, ~b, 1); NEG=2: (~a, 0, 1); ABS=3: (a^{16{a[15]}}, 0, a[15]).
//    Result is modulo 2^16; ABS(0x8000)=0x8000, NEG(0x8000)=0x8000.
//  - Issue condition: can_issue = !res_valid || res_ready (one-stage output register, no bubble).
//  - Arbitration: round-robin starting at pointer. Grant the first i with req_valid[i], searching
//    pointer, pointer+1, ... mod NREQ. req_ready = grant when can_issue, else 0. Grant is
//    combinational from req_valid, so requesters must not make req_valid depend on req_ready.
//  - Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requester holds valid/op/a/b
//    stable until accepted. The result register loads at the same edge.
//    Latency: 1 cycle (res_valid high the cycle after acceptance).
//  - Pointer: on a transfer from i, pointer <= (i+1) mod NREQ. Otherwise unchanged.
//  - Output: if res_valid && !res_ready, res_* hold and no request is accepted.
//    Simultaneous res_ready with a new grant gives back-to-back results every cycle.
//    If no request arrives and res_ready is high, res_valid falls to 0.
//  - Reset mid-operation discards the pending result and any in-flight grant. The pointer
//    returns to 0.
//  - No starvation: a held request is served within NREQ transfers.
// CONFIGURATION
//  PADD_OVF_EN defined: res_ovf is registered with the result.
//    ADD: a[15]==b[15] && s[15]!=a[15]
//    SUB: a[15]!=b[15] && s[15]!=a[15]
//    NEG/ABS: a==16'h8000
//  PADD_OVF_EN undefined: the res_ovf port is absent and no overflow logic is built.
// STRUCTURE
//  - padd_pkg: typedef enum logic[1:0] padd_op_t {ADD,SUB,NEG,ABS}; localparam WIDTH=16.
//  - Sub-module rr_arbiter #(NREQ): inputs req, en, ptr; outputs grant (one-hot) and idx.
//  - padd_sched instantiates rr_arbiter and one padder16, plus the opcode mux and output register.
// TESTING
//  1. Reset: rst=1 for 2 cycles with req_valid=4'hF -> req_ready=0, res_valid=0, res_data=0.
//  2. Single request: r0 ADD 0x7FFF+0x0001 -> next cycle res_data=0x8000, res_id=0
//     (res_ovf=1 with PADD_OVF_EN).
//  3. Opcodes:
//     SUB 0x0005-0x0007 -> 0xFFFE; NEG 0x0003 -> 0xFFFD; ABS 0xFFF6 -> 0x000A;
//     ABS 0x8000 -> 0x8000 (res_ovf=1 with PADD_OVF_EN).
//  4. Fairness: all four requesters held valid, res_ready=1 -> res_id sequence 0,1,2,3,0 on
//     consecutive cycles.
//  5. Backpressure: res_ready=0 for 3 cycles after a result -> res_* stable, req_ready=0.
//     res_ready=1 -> next grant issues the same cycle.
//  6. Reset mid-stream: assert rst while res_valid=1 and the pointer is at 2 ->
//     res_valid=0 next cycle. The next grant goes to requester 0.

Source files
------------

// File: rtl/padd_pkg.sv
// Shared types and constants for the padd_sched shared-adder scheduler.
package padd_pkg;
    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        NEG = 2'd2,
        ABS = 2'd3
    } padd_op_t;
endpackage

// File: rtl/padd_sched_if.sv
// Request/result bus of padd_sched. The res_ovf signal exists only when PADD_OVF_EN is defined.
interface padd_sched_if #(parameter int NREQ = 4);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]                          req_valid;
    logic [NREQ-1:0]                          req_ready;
    logic [NREQ-1:0][1:0]                     req_op;
    logic [NREQ-1:0][padd_pkg::WIDTH-1:0]     req_a;
    logic [NREQ-1:0][padd_pkg::WIDTH-1:0]     req_b;
    logic                                     res_valid;
    logic                                     res_ready;
    logic [padd_pkg::WIDTH-1:0]               res_data;
    logic [ID_W-1:0]                          res_id;
`ifdef PADD_OVF_EN
    logic                                     res_ovf;

    modport master (output req_valid, req_op, req_a, req_b, res_ready,
                    input  req_ready, res_valid, res_data, res_id, res_ovf);
    modport slave  (input  req_valid, req_op, req_a, req_b, res_ready,
                    output req_ready, res_valid, res_data, res_id, res_ovf);
`else
    modport master (output req_valid, req_op, req_a, req_b, res_ready,
                    input  req_ready, res_valid, res_data, res_id);
    modport slave  (input  req_valid, req_op, req_a, req_b, res_ready,
                    output req_ready, res_valid, res_data, res_id);
`endif
endinterface

// File: rtl/padd_sched_arb.sv
// Round-robin arbiter: first requester at or after i_ptr wins; grant is gated by i_en.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_idx
);
    always_comb begin
        int   j;
        logic found;
        j       = 0;
        found   = 1'b0;
        o_idx   = '0;
        o_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (!found && i_req[j]) begin
                found = 1'b1;
                o_idx = ID_W'(j);
            end
        end
        if (i_en && found) o_grant[o_idx] = 1'b1;
    end
endmodule

// File: rtl/padder16.sv
// 16-bit Kogge-Stone prefix adder with carry-in; carry-in is folded into bit 0's generate.
module padder16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum
);
    logic [15:0]      w_p;
    logic [4:0][14:0] w_g;
    logic [3:0][14:0] w_pp;

    assign w_p     = i_a ^ i_b;
    assign w_g[0]  = (i_a[14:0] & i_b[14:0]) | {14'd0, w_p[0] & i_cin};
    assign w_pp[0] = w_p[14:0];

    // Bits below the span D are already resolved; the mask keeps their group-propagate inert.
    for (genvar k = 0; k < 4; k++) begin : g_lvl
        localparam int D = 1 << k;
        assign w_g[k+1] = w_g[k] | (w_pp[k] & (w_g[k] << D));
        if (k < 3) begin : g_p
            assign w_pp[k+1] = w_pp[k] & ((w_pp[k] << D) | 15'((1 << D) - 1));
        end
    end

    assign o_sum = w_p ^ {w_g[4], i_cin};
endmodule

// File: rtl/padd_sched.sv
// Shares one padder16 among NREQ requesters: round-robin issue, opcode mapping, registered result.
// Optional overflow flag under PADD_OVF_EN.
module padd_sched import padd_pkg::*; #(
    parameter int NREQ = 4
) (
    input  logic         clk,
    input  logic         rst,
    padd_sched_if.slave  bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ID_W-1:0]  r_ptr;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [ID_W-1:0]  r_res_id;

    logic             w_can_issue;
    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_fire;
    padd_op_t         w_op;
    logic [WIDTH-1:0] w_opa, w_opb, w_a, w_b, w_sum;
    logic             w_cin;

    // Output stage never bubbles: a new result may replace one being consumed this cycle.
    assign w_can_issue = !r_res_valid || bus.res_ready;
    assign w_fire      = |w_grant;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (bus.req_valid),
        .i_en    (w_can_issue && !rst),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign bus.req_ready = w_grant;
    assign w_op  = padd_op_t'(bus.req_op[w_idx]);
    assign w_opa = bus.req_a[w_idx];
    assign w_opb = bus.req_b[w_idx];

    always_comb begin
        w_a   = w_opa;
        w_b   = w_opb;
        w_cin = 1'b0;
        case (w_op)
            ADD: ;
            SUB: begin w_b = ~w_opb; w_cin = 1'b1; end
            NEG: begin w_a = ~w_opa; w_b = '0; w_cin = 1'b1; end
            ABS: begin w_a = w_opa ^ {WIDTH{w_opa[WIDTH-1]}}; w_b = '0; w_cin = w_opa[WIDTH-1]; end
            default: ;
        endcase
    end

    padder16 u_add (.i_a(w_a), .i_b(w_b), .i_cin(w_cin), .o_sum(w_sum));

`ifdef PADD_OVF_EN
    logic r_res_ovf;
    logic w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        case (w_op)
            ADD:     w_ovf = (w_opa[15] == w_opb[15]) && (w_sum[15] != w_opa[15]);
            SUB:     w_ovf = (w_opa[15] != w_opb[15]) && (w_sum[15] != w_opa[15]);
            default: w_ovf = (w_opa == 16'h8000);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         r_res_ovf <= 1'b0;
        else if (w_fire) r_res_ovf <= w_ovf;
    end

    assign bus.res_ovf = r_res_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_ptr       <= '0;
        end else if (w_fire) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_sum;
            r_res_id    <= w_idx;
            r_ptr       <= (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_id    = r_res_id;
endmodule

// File: tb/tb_padd_sched.sv
// Self-checking bench for padd_sched: directed scenarios followed by a randomized run against
// a transaction-level model (signed arithmetic reference, pending-request table, rr order).
module tb_padd_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    padd_sched_if #(.NREQ(N)) bus ();
    padd_sched #(.NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed arithmetic, overflow when the true result leaves the 16-bit signed range.
    function automatic logic [16:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = -sa;
            default: r = (sa < 0) ? -sa : sa;
        endcase
        return {(r > 32767 || r < -32768), r[15:0]};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check_res(input string tag, input int id, input logic [16:0] exp);
        chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.res_data), 32'(exp[15:0]));
        chk({tag, "_id"}, 32'(bus.res_id), 32'(id));
`ifdef PADD_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.res_ovf), 32'(exp[16]));
`endif
    endtask

    // Lone request from one requester with res_ready high; result checked one cycle later.
    task automatic single(input string tag, input int id, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b);
        bus.req_valid     = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_op[id]    = op;
        bus.req_a[id]     = a;
        bus.req_b[id]     = b;
        bus.res_ready     = 1'b1;
        #1 chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(1 << id));
        tick();
        bus.req_valid = '0;
        check_res(tag, id, ref_op(op, a, b));
    endtask

    task automatic all_valid_add();
        for (int i = 0; i < N; i++) begin
            bus.req_op[i] = 2'd0;
            bus.req_a[i]  = 16'(i + 1);
            bus.req_b[i]  = 16'h0100;
        end
        bus.req_valid = '1;
    endtask

    bit          pend  [N];
    logic [1:0]  p_op  [N];
    logic [15:0] p_a   [N];
    logic [15:0] p_b   [N];
    int          waitc [N];

    initial begin
        int          ptr_m, g, exp_id;
        bit          exp_v, can;
        logic [16:0] exp_r;

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;

        // Reset with every requester asking
        rst = 1'b1;
        bus.req_valid = '1;
        tick();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_data", 32'(bus.res_data), 32'd0);
        chk("rst_id", 32'(bus.res_id), 32'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        single("add_ovf", 0, 2'd0, 16'h7FFF, 16'h0001);
        single("sub", 1, 2'd1, 16'h0005, 16'h0007);
        single("neg", 2, 2'd2, 16'h0003, 16'h1234);
        single("abs", 3, 2'd3, 16'hFFF6, 16'h5555);
        single("abs_min", 0, 2'd3, 16'h8000, 16'h0000);
        single("neg_min", 1, 2'd2, 16'h8000, 16'h0000);
        tick();
        chk("drain_valid", 32'(bus.res_valid), 32'd0);

        // Fairness from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        all_valid_add();
        bus.res_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1 chk("fair_rdy", 32'(bus.req_ready), 32'(1 << (s % N)));
            tick();
            chk("fair_id", 32'(bus.res_id), 32'(s % N));
            chk("fair_data", 32'(bus.res_data), 32'((s % N) + 1 + 16'h0100));
        end

        // Backpressure: result from requester 0 must hold, nothing accepted
        bus.res_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1 chk("bp_rdy", 32'(bus.req_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_id", 32'(bus.res_id), 32'd0);
            chk("bp_data", 32'(bus.res_data), 32'h0101);
        end
        bus.res_ready = 1'b1;
        #1 chk("bp_rel_rdy", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("bp_rel_id", 32'(bus.res_id), 32'd1);
        chk("bp_rel_data", 32'(bus.res_data), 32'h0102);

        // Mid-stream reset with pointer at 2 and a result pending
        rst = 1'b1;
        #1 chk("mrst_rdy", 32'(bus.req_ready), 32'd0);
        tick();
        chk("mrst_valid", 32'(bus.res_valid), 32'd0);
        chk("mrst_data", 32'(bus.res_data), 32'd0);
        rst = 1'b0;
        #1 chk("mrst_rdy0", 32'(bus.req_ready), 32'b0001);
        tick();
        chk("mrst_id", 32'(bus.res_id), 32'd0);

        // Randomized run from a clean state
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        ptr_m = 0;
        exp_v = 1'b0;
        exp_id = 0;
        exp_r = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            waitc[i] = 0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    p_op[i]  = 2'($urandom_range(0, 3));
                    p_a[i]   = rnd16();
                    p_b[i]   = rnd16();
                    waitc[i] = 0;
                end
                bus.req_valid[i] = pend[i];
                bus.req_op[i]    = p_op[i];
                bus.req_a[i]     = p_a[i];
                bus.req_b[i]     = p_b[i];
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
            can = !exp_v || bus.res_ready;
            g = -1;
            if (can)
                for (int k = 0; k < N; k++)
                    if (g < 0 && pend[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            #1 chk("rnd_rdy", 32'(bus.req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
            tick();
            if (g >= 0) begin
                exp_r  = ref_op(p_op[g], p_a[g], p_b[g]);
                exp_id = g;
                exp_v  = 1'b1;
                ptr_m  = (g + 1) % N;
                pend[g] = 1'b0;
                chk("rnd_wait", 32'(waitc[g] < N), 32'd1);
                for (int i = 0; i < N; i++) if (pend[i]) waitc[i]++;
            end else if (bus.res_ready) begin
                exp_v = 1'b0;
            end
            if (exp_v) check_res("rnd", exp_id, exp_r);
            else chk("rnd_valid", 32'(bus.res_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
